// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        WAIT_IDLE
    } state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef struct packed {
        logic perr;
        logic ferr;
        logic brk;
    } rx_flags_t;

    function automatic int unsigned ctr_width(input int unsigned div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Synchroniser, bit-phase counter and 3-sample majority vote for one serial line.
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rxd,
    input  logic ph_clr,
    output logic level,
    output logic fall_c,
    output logic vote_stb_c,
    output logic vote_c,
    output logic bit_end_c
);

    localparam int unsigned PW   = ctr_width(CLK_DIV);
    localparam int unsigned HALF = CLK_DIV / 2;

    logic [1:0]    sync;
    logic          prev;
    logic [PW-1:0] ph;
    logic          s0;
    logic          s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
            prev <= 1'b1;
            ph   <= '0;
            s0   <= 1'b1;
            s1   <= 1'b1;
        end else begin
            sync <= {sync[0], rxd};
            prev <= sync[1];
            if (ph_clr || ph == PW'(CLK_DIV - 1)) begin
                ph <= '0;
            end else begin
                ph <= ph + PW'(1);
            end
            if (ph == PW'(HALF - 1)) s0 <= sync[1];
            if (ph == PW'(HALF))     s1 <= sync[1];
        end
    end

    // Third sample is the live synchronised level at HALF+1.
    assign level      = sync[1];
    assign fall_c     = prev & ~sync[1];
    assign vote_stb_c = (ph == PW'(HALF + 1));
    assign vote_c     = (s0 & s1) | (s0 & sync[1]) | (s1 & sync[1]);
    assign bit_end_c  = (ph == PW'(CLK_DIV - 1));

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with majority-voted bits, error flags and a valid/ready holding register.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned CLK_DIV   = 434,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 MCLK,
    input  logic                 HRST_N,
    input  logic                 i_RXD,
    output logic [DATA_BITS-1:0] o_DATA,
    output logic                 o_VALID,
    input  logic                 i_READY,
    output logic                 o_PERR,
    output logic                 o_FERR,
    output logic                 o_BREAK,
    output logic                 o_OVERRUN
);

    localparam int unsigned CW = 4;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [DATA_BITS-1:0]  sh;
    logic                  par_bit;
    logic                  ferr_acc;
    logic                  all_zero;

    logic      level;
    logic      fall_c;
    logic      vote_stb_c;
    logic      vote_c;
    logic      bit_end_c;
    logic      ph_clr_c;
    logic      done_c;
    logic      par_exp_c;
    rx_flags_t flags_c;

    uart_bit_sampler #(
        .CLK_DIV (CLK_DIV)
    ) u_sampler (
        .clk        (MCLK),
        .rst_n      (HRST_N),
        .rxd        (i_RXD),
        .ph_clr     (ph_clr_c),
        .level      (level),
        .fall_c     (fall_c),
        .vote_stb_c (vote_stb_c),
        .vote_c     (vote_c),
        .bit_end_c  (bit_end_c)
    );

    // Phase is held at zero while idle so START begins at ph=0.
    assign ph_clr_c  = (state == IDLE);
    assign done_c    = (state == STOP) && vote_stb_c && (cnt == CW'(STOP_BITS - 1));
    assign par_exp_c = (PARITY == PAR_ODD) ? ~(^sh) : ^sh;

    always_comb begin
        flags_c      = '0;
        flags_c.perr = (PARITY != PAR_NONE) && (par_bit != par_exp_c);
        flags_c.ferr = ferr_acc | ~vote_c;
        flags_c.brk  = all_zero & ~vote_c;
    end

    // Frame sequencer.
    always_ff @(posedge MCLK or negedge HRST_N) begin
        if (!HRST_N) begin
            state    <= IDLE;
            cnt      <= '0;
            sh       <= '0;
            par_bit  <= 1'b0;
            ferr_acc <= 1'b0;
            all_zero <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (fall_c) begin
                        state    <= START;
                        cnt      <= '0;
                        ferr_acc <= 1'b0;
                        all_zero <= 1'b1;
                        par_bit  <= 1'b0;
                    end
                end
                START: begin
                    if (vote_stb_c && vote_c) begin
                        state <= IDLE;
                    end else if (bit_end_c) begin
                        state <= DATA;
                        cnt   <= '0;
                    end
                end
                DATA: begin
                    if (vote_stb_c) begin
                        sh       <= {vote_c, sh[DATA_BITS-1:1]};
                        all_zero <= all_zero & ~vote_c;
                    end
                    if (bit_end_c) begin
                        if (cnt == CW'(DATA_BITS - 1)) begin
                            cnt   <= '0;
                            state <= (PARITY != PAR_NONE) ? PAR : STOP;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                PAR: begin
                    if (vote_stb_c) begin
                        par_bit  <= vote_c;
                        all_zero <= all_zero & ~vote_c;
                    end
                    if (bit_end_c) begin
                        state <= STOP;
                        cnt   <= '0;
                    end
                end
                STOP: begin
                    if (vote_stb_c) begin
                        ferr_acc <= ferr_acc | ~vote_c;
                        all_zero <= all_zero & ~vote_c;
                        if (cnt == CW'(STOP_BITS - 1)) begin
                            state <= vote_c ? IDLE : WAIT_IDLE;
                        end
                    end
                    if (bit_end_c) cnt <= cnt + CW'(1);
                end
                WAIT_IDLE: begin
                    if (level) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Holding register: a completed frame loads only if the slot is free or being drained.
    always_ff @(posedge MCLK or negedge HRST_N) begin
        if (!HRST_N) begin
            o_DATA    <= '0;
            o_VALID   <= 1'b0;
            o_PERR    <= 1'b0;
            o_FERR    <= 1'b0;
            o_BREAK   <= 1'b0;
            o_OVERRUN <= 1'b0;
        end else begin
            o_OVERRUN <= 1'b0;
            if (done_c) begin
                if (!o_VALID || i_READY) begin
                    o_DATA  <= sh;
                    o_PERR  <= flags_c.perr;
                    o_FERR  <= flags_c.ferr;
                    o_BREAK <= flags_c.brk;
                    o_VALID <= 1'b1;
                end else begin
                    o_OVERRUN <= 1'b1;
                end
            end else if (o_VALID && i_READY) begin
                o_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param in an 8E2 configuration with CLK_DIV=16.
module tb_uart_rx_param;

    localparam int unsigned DB  = 8;
    localparam int unsigned DIV = 16;
    // Drive-to-valid: 2 sync + 1 IDLE decode, then 11 bit periods + HALF+1 + 1 register edge.
    localparam int LAT = 3 + 11 * 16 + 9 + 1;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } word_t;

    typedef struct {
        logic [7:0] d;
        logic       pb;
        logic       s0;
        logic       s1;
        word_t      exp;
    } vec_t;

    logic          MCLK = 1'b0;
    logic          HRST_N;
    logic          i_RXD;
    logic [DB-1:0] o_DATA;
    logic          o_VALID;
    logic          i_READY;
    logic          o_PERR;
    logic          o_FERR;
    logic          o_BREAK;
    logic          o_OVERRUN;

    int    n_tot = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    fall_cyc = 0;
    int    rise_cyc = 0;
    int    n_ovr = 0;
    logic  v_prev = 1'b0;
    word_t got[$];

    uart_rx_param #(
        .DATA_BITS (DB),
        .CLK_DIV   (DIV),
        .PARITY    (2),
        .STOP_BITS (2)
    ) dut (
        .MCLK      (MCLK),
        .HRST_N    (HRST_N),
        .i_RXD     (i_RXD),
        .o_DATA    (o_DATA),
        .o_VALID   (o_VALID),
        .i_READY   (i_READY),
        .o_PERR    (o_PERR),
        .o_FERR    (o_FERR),
        .o_BREAK   (o_BREAK),
        .o_OVERRUN (o_OVERRUN)
    );

    always #5 MCLK = ~MCLK;
    always @(posedge MCLK) cyc <= cyc + 1;

    // Output monitor: collects accepted words and overrun pulses.
    always @(negedge MCLK) begin
        if (HRST_N) begin
            if (o_VALID && !v_prev) rise_cyc = cyc;
            v_prev = o_VALID;
            if (o_VALID && i_READY) got.push_back({o_DATA, o_PERR, o_FERR, o_BREAK});
            if (o_OVERRUN) n_ovr++;
        end else begin
            v_prev = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge MCLK);
            #1;
        end
    endtask

    task automatic send_bit(input logic v, input int spike);
        for (int j = 0; j < int'(DIV); j++) begin
            i_RXD = (j == spike) ? ~v : v;
            tick(1);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pb, input logic s0,
                              input logic s1, input int spike_bit);
        fall_cyc = cyc;
        send_bit(1'b0, -1);
        for (int i = 0; i < 8; i++) send_bit(d[i], (i == spike_bit) ? 9 : -1);
        send_bit(pb, -1);
        send_bit(s0, -1);
        send_bit(s1, -1);
        i_RXD = 1'b1;
    endtask

    task automatic wait_word(input string name, output word_t w);
        int k;
        k = 0;
        while (got.size() == 0 && k < 400) begin
            tick(1);
            k++;
        end
        if (got.size() == 0) begin
            n_tot++;
            n_bad++;
            $display("FAIL %s: no word within 400 cycles", name);
            w = '0;
        end else begin
            w = got.pop_front();
        end
    endtask

    // Reference: the word a frame must produce, from the framing rules alone (even parity).
    function automatic word_t model(input logic [7:0] d, input logic pb, input logic s0, input logic s1);
        word_t r;
        r.data = d;
        r.perr = (pb != ^d);
        r.ferr = !(s0 && s1);
        r.brk  = (d == 8'h00) && !pb && !s0 && !s1;
        return r;
    endfunction

    initial begin
        vec_t  tbl[10];
        word_t w;
        int    ovr0;
        logic [7:0] rd;
        logic rp, r0, r1;

        tbl[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, '{8'hA5, 1'b0, 1'b0, 1'b0}};
        tbl[1] = '{8'h03, 1'b1, 1'b1, 1'b1, '{8'h03, 1'b1, 1'b0, 1'b0}};
        tbl[2] = '{8'h03, 1'b0, 1'b1, 1'b1, '{8'h03, 1'b0, 1'b0, 1'b0}};
        tbl[3] = '{8'h80, 1'b1, 1'b1, 1'b1, '{8'h80, 1'b0, 1'b0, 1'b0}};
        tbl[4] = '{8'h7E, 1'b0, 1'b1, 1'b1, '{8'h7E, 1'b0, 1'b0, 1'b0}};
        tbl[5] = '{8'hFF, 1'b0, 1'b0, 1'b1, '{8'hFF, 1'b0, 1'b1, 1'b0}};
        tbl[6] = '{8'h00, 1'b0, 1'b0, 1'b0, '{8'h00, 1'b0, 1'b1, 1'b1}};
        tbl[7] = '{8'h00, 1'b1, 1'b0, 1'b0, '{8'h00, 1'b1, 1'b1, 1'b0}};
        tbl[8] = '{8'h01, 1'b1, 1'b1, 1'b0, '{8'h01, 1'b0, 1'b1, 1'b0}};
        tbl[9] = '{8'h5A, 1'b0, 1'b1, 1'b1, '{8'h5A, 1'b0, 1'b0, 1'b0}};

        HRST_N  = 1'b0;
        i_RXD   = 1'b1;
        i_READY = 1'b1;
        tick(5);
        check("reset_outputs", 32'({o_DATA, o_VALID, o_PERR, o_FERR, o_BREAK, o_OVERRUN}), 32'h0);
        HRST_N = 1'b1;
        tick(5);

        for (int i = 0; i < 10; i++) begin
            send_frame(tbl[i].d, tbl[i].pb, tbl[i].s0, tbl[i].s1, -1);
            wait_word($sformatf("tbl%0d_wait", i), w);
            check($sformatf("tbl%0d_word", i), 32'(w), 32'(tbl[i].exp));
            if (i == 0) check("latency", 32'(rise_cyc - fall_cyc), 32'(LAT));
            tick(4);
        end

        // Short low glitch must be rejected as a false start.
        i_RXD = 1'b0;
        tick(3);
        i_RXD = 1'b1;
        tick(16 * 15);
        check("glitch_no_word", 32'(got.size()), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, -1);
        wait_word("after_glitch_wait", w);
        check("after_glitch_word", 32'(w), 32'({8'h5A, 3'b000}));
        tick(4);

        // Held word with a stalled consumer; second frame is dropped.
        i_READY = 1'b0;
        ovr0 = n_ovr;
        send_frame(8'h11, 1'b0, 1'b1, 1'b1, -1);
        tick(4);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1, -1);
        tick(4);
        check("ovr_held", 32'({o_VALID, o_DATA}), 32'({1'b1, 8'h11}));
        check("ovr_pulses", 32'(n_ovr - ovr0), 32'd1);
        i_READY = 1'b1;
        tick(2);
        check("ovr_drain_valid", 32'(o_VALID), 32'd0);
        check("ovr_drain_count", 32'(got.size()), 32'd1);
        wait_word("ovr_drain_wait", w);
        check("ovr_drain_word", 32'(w), 32'({8'h11, 3'b000}));
        tick(4);

        // Line low for 20 bit times: one break word, no retrigger.
        i_RXD = 1'b0;
        tick(20 * 16);
        check("break_count", 32'(got.size()), 32'd1);
        wait_word("break_wait", w);
        check("break_word", 32'(w), 32'({8'h00, 3'b011}));
        tick(64);
        check("break_no_retrigger", 32'(got.size()), 32'd0);
        i_RXD = 1'b1;
        tick(8);
        send_frame(8'h7E, 1'b0, 1'b1, 1'b1, -1);
        wait_word("after_break_wait", w);
        check("after_break_word", 32'(w), 32'({8'h7E, 3'b000}));
        tick(4);

        // One-cycle spike at the centre of data bit 2 is outvoted.
        send_frame(8'hC3, 1'b0, 1'b1, 1'b1, 2);
        wait_word("spike_wait", w);
        check("spike_word", 32'(w), 32'({8'hC3, 3'b000}));
        tick(4);

        // Reset mid-frame discards it.
        fall_cyc = cyc;
        send_bit(1'b0, -1);
        send_bit(1'b1, -1);
        send_bit(1'b0, -1);
        i_RXD  = 1'b1;
        HRST_N = 1'b0;
        tick(3);
        check("midreset_outputs", 32'({o_DATA, o_VALID, o_PERR, o_FERR, o_BREAK, o_OVERRUN}), 32'h0);
        HRST_N = 1'b1;
        tick(16 * 14);
        check("midreset_no_word", 32'({o_VALID, 8'(got.size())}), 32'h0);

        // Randomised frames against the framing model.
        for (int i = 0; i < 25; i++) begin
            rd = 8'($urandom);
            rp = (^rd) ^ ($urandom_range(0, 3) == 0);
            r0 = ($urandom_range(0, 4) != 0);
            r1 = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 7) == 0) begin
                rd = 8'h00;
                rp = 1'b0;
                r0 = 1'b0;
                r1 = 1'b0;
            end
            send_frame(rd, rp, r0, r1, -1);
            wait_word($sformatf("rand%0d_wait", i), w);
            check($sformatf("rand%0d_word", i), 32'(w), 32'(model(rd, rp, r0, r1)));
            tick(2 + int'($urandom_range(0, 9)));
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
